// File: rtl/gmii_mon_pkg.sv
// Shared types and constants for the GMII link monitor slice.
package gmii_mon_pkg;

    typedef enum logic [1:0] {
        DOWN = 2'd0,
        QUAL = 2'd1,
        UP   = 2'd2
    } link_state_e;

    localparam int ST_LINK_BIT = 0;
    localparam int ST_SYNC_BIT = 1;
    localparam int GMII_W      = 8;

endpackage

// File: rtl/gmii_mon_sat_cnt.sv
// Saturating statistics counter: counts inc pulses, sticks at all-ones,
// and a clear in the same cycle as an increment wins.
module gmii_mon_sat_cnt #(
    parameter int W = 32
) (
    input  logic         userclk2,
    input  logic         sys0_rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up until all-ones, clear takes priority over increment
    always_ff @(posedge userclk2 or posedge sys0_rst) begin
        if (sys0_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gmii_link_monitor.sv
// GMII TX retiming stage with RX/TX link monitor on the userclk2 domain.
// Optional TX inter-frame-gap checking is enabled by defining the macro
// GMII_LINK_MONITOR_IFG_CHECK_EN; otherwise ifg_viol is held at zero.
module gmii_link_monitor
    import gmii_mon_pkg::*;
#(
    parameter int TX_PIPE   = 1,
    parameter int STATUS_W  = 16,
    parameter int CNT_W     = 32,
    parameter int LINK_DBNC = 1024,
    parameter int IFG_MIN   = 12
) (
    input  logic                userclk2,
    input  logic                sys0_rst,
    input  logic                clr,
    input  logic [GMII_W-1:0]   mac_txd,
    input  logic                mac_tx_en,
    input  logic                mac_tx_er,
    output logic [GMII_W-1:0]   pcs_txd,
    output logic                pcs_tx_en,
    output logic                pcs_tx_er,
    input  logic [GMII_W-1:0]   gmii_rxd,
    input  logic                gmii_rx_dv,
    input  logic                gmii_rx_er,
    input  logic [STATUS_W-1:0] status_vector,
    output logic                link_up,
    output logic                dbg_or,
    output logic [STATUS_W-1:0] status_sticky,
    output logic [CNT_W-1:0]    tx_frames,
    output logic [CNT_W-1:0]    rx_frames,
    output logic [CNT_W-1:0]    rx_err_frames,
    output logic [CNT_W-1:0]    ifg_viol
);

    localparam int DW = (LINK_DBNC > 2) ? $clog2(LINK_DBNC) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(LINK_DBNC - 1);

    // RX data is observed only; fold it so the port is visibly consumed
    logic unused_rxd;
    assign unused_rxd = ^gmii_rxd;

    generate
        if (TX_PIPE == 0) begin : g_tx_wire
            assign pcs_txd   = mac_txd;
            assign pcs_tx_en = mac_tx_en;
            assign pcs_tx_er = mac_tx_er;
        end else begin : g_tx_pipe
            logic [GMII_W+1:0] pipe_q [TX_PIPE];

            // Shift the TX word through TX_PIPE register stages
            always_ff @(posedge userclk2 or posedge sys0_rst) begin
                if (sys0_rst) begin
                    for (int i = 0; i < TX_PIPE; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= {mac_tx_er, mac_tx_en, mac_txd};
                    for (int i = 1; i < TX_PIPE; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign {pcs_tx_er, pcs_tx_en, pcs_txd} = pipe_q[TX_PIPE-1];
        end
    endgenerate

    logic [STATUS_W-1:0] st_q;

    // Register PCS status, its OR for debug, and the sticky accumulation
    always_ff @(posedge userclk2 or posedge sys0_rst) begin
        if (sys0_rst) begin
            st_q          <= '0;
            dbg_or        <= 1'b0;
            status_sticky <= '0;
        end else begin
            st_q          <= status_vector;
            dbg_or        <= |st_q;
            status_sticky <= clr ? '0 : (status_sticky | st_q);
        end
    end

    link_state_e   state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          good;

    assign good = st_q[ST_LINK_BIT] & st_q[ST_SYNC_BIT];

    // Link FSM state, qualification counter and registered link_up
    always_ff @(posedge userclk2 or posedge sys0_rst) begin
        if (sys0_rst) begin
            state_q <= DOWN;
            dcnt_q  <= '0;
            link_up <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            link_up <= (state_d == UP);
        end
    end

    // Link goes up only after a full run of good cycles, drops immediately
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            DOWN: begin
                if (good) begin
                    state_d = QUAL;
                    dcnt_d  = '0;
                end
            end
            QUAL: begin
                if (!good) begin
                    state_d = DOWN;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = UP;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            UP: begin
                if (!good) state_d = DOWN;
            end
            default: state_d = DOWN;
        endcase
    end

    // A frame only counts if its start was seen; prev flags reset high so a
    // frame already running when reset releases is ignored.
    logic tx_prev, tx_open, rx_prev, rx_open, rx_err_flag;
    logic tx_start, tx_end, rx_start, rx_end, rx_err_end;

    assign tx_start   = mac_tx_en & ~tx_prev;
    assign tx_end     = tx_open & ~mac_tx_en;
    assign rx_start   = gmii_rx_dv & ~rx_prev;
    assign rx_end     = rx_open & ~gmii_rx_dv;
    assign rx_err_end = rx_end & (rx_err_flag | gmii_rx_er);

    // Track frame boundaries on TX and RX plus the per-frame RX error flag
    always_ff @(posedge userclk2 or posedge sys0_rst) begin
        if (sys0_rst) begin
            tx_prev     <= 1'b1;
            tx_open     <= 1'b0;
            rx_prev     <= 1'b1;
            rx_open     <= 1'b0;
            rx_err_flag <= 1'b0;
        end else begin
            tx_prev     <= mac_tx_en;
            tx_open     <= tx_start | (tx_open & mac_tx_en);
            rx_prev     <= gmii_rx_dv;
            rx_open     <= rx_start | (rx_open & gmii_rx_dv);
            rx_err_flag <= gmii_rx_dv & (rx_err_flag | gmii_rx_er);
        end
    end

    gmii_mon_sat_cnt #(.W(CNT_W)) u_tx_cnt (
        .userclk2(userclk2), .sys0_rst(sys0_rst),
        .inc(tx_end), .clr(clr), .cnt(tx_frames)
    );

    gmii_mon_sat_cnt #(.W(CNT_W)) u_rx_cnt (
        .userclk2(userclk2), .sys0_rst(sys0_rst),
        .inc(rx_end), .clr(clr), .cnt(rx_frames)
    );

    gmii_mon_sat_cnt #(.W(CNT_W)) u_rx_err_cnt (
        .userclk2(userclk2), .sys0_rst(sys0_rst),
        .inc(rx_err_end), .clr(clr), .cnt(rx_err_frames)
    );

`ifdef GMII_LINK_MONITOR_IFG_CHECK_EN
    localparam int GW = $clog2(IFG_MIN + 1);
    localparam logic [GW-1:0] GAP_SAT = GW'(IFG_MIN);

    logic [GW-1:0] gap_q;
    logic          ifg_short;

    assign ifg_short = tx_start & (gap_q < GAP_SAT);

    // Count idle TX cycles up to IFG_MIN, restarting at every frame start
    always_ff @(posedge userclk2 or posedge sys0_rst) begin
        if (sys0_rst) begin
            gap_q <= GAP_SAT;
        end else if (tx_start) begin
            gap_q <= '0;
        end else if (!mac_tx_en && (gap_q != GAP_SAT)) begin
            gap_q <= gap_q + 1'b1;
        end
    end

    gmii_mon_sat_cnt #(.W(CNT_W)) u_ifg_cnt (
        .userclk2(userclk2), .sys0_rst(sys0_rst),
        .inc(ifg_short), .clr(clr), .cnt(ifg_viol)
    );
`else
    localparam int unused_ifg_min = IFG_MIN;
    assign ifg_viol = '0;
`endif

endmodule
